// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// FSM states, datapath select codes and the one-hot instruction class.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MD     = 3'd5
  } state_e;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_JAL = 2'b10;
  localparam logic [1:0] NPC_RS  = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  localparam logic [1:0] A3_RD   = 2'b00;
  localparam logic [1:0] A3_RT   = 2'b01;
  localparam logic [1:0] A3_RA   = 2'b10;

  localparam logic [2:0] WD_ALU  = 3'b000;
  localparam logic [2:0] WD_DM   = 3'b001;
  localparam logic [2:0] WD_PC4  = 3'b010;
  localparam logic [2:0] WD_LUI  = 3'b011;
  localparam logic [2:0] WD_HI   = 3'b100;
  localparam logic [2:0] WD_LO   = 3'b101;

  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  // Exactly one field is set for any opcode/funct pair.
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
    logic jr;
    logic lui;
    logic mult;
    logic div;
    logic mfhi;
    logic mflo;
    logic unknown;
  } insn_t;

  function automatic int unsigned max_lat(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: IR opcode/funct to a one-hot class.
module mc_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output insn_t      insn
);

  always_comb begin
    insn = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: insn.addu = 1'b1;
          FN_SUBU: insn.subu = 1'b1;
          FN_JR:   insn.jr   = 1'b1;
          FN_MULT: insn.mult = 1'b1;
          FN_DIV:  insn.div  = 1'b1;
          FN_MFHI: insn.mfhi = 1'b1;
          FN_MFLO: insn.mflo = 1'b1;
          default: insn.unknown = 1'b1;
        endcase
      end
      OP_ORI:  insn.ori = 1'b1;
      OP_LW:   insn.lw  = 1'b1;
      OP_SW:   insn.sw  = 1'b1;
      OP_BEQ:  insn.beq = 1'b1;
      OP_JAL:  insn.jal = 1'b1;
      OP_LUI:  insn.lui = 1'b1;
      default: insn.unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencing plus a
// fixed-latency mult/div wait state; outputs are Moore decodes of state + IR.
module mc_controller
  import mips_ctrl_pkg::*;
#(
  parameter  int MULT_LAT = 5,
  parameter  int DIV_LAT  = 10,
  localparam int CNT_W    = $clog2(max_lat(MULT_LAT, DIV_LAT) + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             PCWr,
  output logic             IRWr,
  output logic [1:0]       NPCOp,
  output logic             GRFWr,
  output logic             EXTOp,
  output logic [1:0]       ALUOp,
  output logic             DMWr,
  output logic [1:0]       A3Sel,
  output logic [2:0]       WDSel,
  output logic             BSel,
  output logic [1:0]       MDStart,
  output logic             MDBusy,
  output logic             retire,
  output state_e           state_dbg,
  output logic [CNT_W-1:0] md_cnt_dbg
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

  state_e           state;
  logic [CNT_W-1:0] md_cnt;
  logic             md_entry;
  insn_t            insn;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .insn   (insn)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      md_cnt   <= '0;
      md_entry <= 1'b0;
    end else begin
      md_entry <= 1'b0;
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (insn.jr || insn.unknown) begin
            state <= S_FETCH;
          end else if (insn.jal || insn.mfhi || insn.mflo) begin
            state <= S_WB;
          end else if (insn.mult || insn.div) begin
            state    <= S_MD;
            md_entry <= 1'b1;
            md_cnt   <= insn.div ? DIV_LOAD : MULT_LOAD;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (insn.beq)                state <= S_FETCH;
          else if (insn.lw || insn.sw) state <= S_MEM;
          else                         state <= S_WB;
        end
        S_MEM:   state <= insn.sw ? S_FETCH : S_WB;
        S_WB:    state <= S_FETCH;
        S_MD: begin
          // Counter saturates at zero; the zero cycle is the retiring one.
          if (md_cnt == '0) state  <= S_FETCH;
          else              md_cnt <= md_cnt - 1'b1;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    NPCOp   = NPC_PC4;
    GRFWr   = 1'b0;
    EXTOp   = 1'b0;
    ALUOp   = ALU_ADD;
    DMWr    = 1'b0;
    A3Sel   = A3_RD;
    WDSel   = WD_ALU;
    BSel    = 1'b0;
    MDStart = MD_NONE;
    MDBusy  = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: IRWr = 1'b1;
        S_DECODE: begin
          if (insn.jr) begin
            PCWr  = 1'b1;
            NPCOp = NPC_RS;
          end else if (insn.unknown) begin
            PCWr  = 1'b1;
          end
        end
        S_EXEC, S_MEM, S_WB: begin
          // ALU controls stay asserted until the instruction retires.
          if (insn.addu) ALUOp = ALU_ADD;
          if (insn.subu) ALUOp = ALU_SUB;
          if (insn.beq) begin
            ALUOp = ALU_SUB;
            EXTOp = 1'b1;
          end
          if (insn.ori) begin
            ALUOp = ALU_OR;
            BSel  = 1'b1;
            EXTOp = 1'b0;
          end
          if (insn.lw || insn.sw) begin
            ALUOp = ALU_ADD;
            BSel  = 1'b1;
            EXTOp = 1'b1;
          end
          if (state == S_EXEC && insn.beq) begin
            PCWr  = 1'b1;
            NPCOp = zero ? NPC_BR : NPC_PC4;
          end
          if (state == S_MEM && insn.sw) begin
            DMWr = 1'b1;
            PCWr = 1'b1;
          end
          if (state == S_WB) begin
            GRFWr = 1'b1;
            PCWr  = 1'b1;
            NPCOp = insn.jal ? NPC_JAL : NPC_PC4;
            if (insn.addu || insn.subu) begin
              A3Sel = A3_RD;
              WDSel = WD_ALU;
            end
            if (insn.ori) begin
              A3Sel = A3_RT;
              WDSel = WD_ALU;
            end
            if (insn.lui) begin
              A3Sel = A3_RT;
              WDSel = WD_LUI;
            end
            if (insn.lw) begin
              A3Sel = A3_RT;
              WDSel = WD_DM;
            end
            if (insn.jal) begin
              A3Sel = A3_RA;
              WDSel = WD_PC4;
            end
            if (insn.mfhi) begin
              A3Sel = A3_RD;
              WDSel = WD_HI;
            end
            if (insn.mflo) begin
              A3Sel = A3_RD;
              WDSel = WD_LO;
            end
          end
        end
        S_MD: begin
          MDBusy = 1'b1;
          if (md_entry) MDStart = insn.div ? MD_DIV : MD_MULT;
          if (md_cnt == '0) PCWr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign retire     = PCWr;
  assign state_dbg  = state;
  assign md_cnt_dbg = md_cnt;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus a random
// instruction stream, each checked against a per-instruction reference table.
module tb_mc_controller;
  import mips_ctrl_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int MAX_CYC  = 40;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       PCWr, IRWr, GRFWr, EXTOp, DMWr, BSel, MDBusy, retire;
  logic [1:0] NPCOp, ALUOp, A3Sel, MDStart;
  logic [2:0] WDSel;
  state_e     state_dbg;
  logic [3:0] md_cnt_dbg;

  int tests = 0;
  int fails = 0;

  mc_controller #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWr(PCWr), .IRWr(IRWr), .NPCOp(NPCOp), .GRFWr(GRFWr), .EXTOp(EXTOp),
    .ALUOp(ALUOp), .DMWr(DMWr), .A3Sel(A3Sel), .WDSel(WDSel), .BSel(BSel),
    .MDStart(MDStart), .MDBusy(MDBusy), .retire(retire),
    .state_dbg(state_dbg), .md_cnt_dbg(md_cnt_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What one instruction should look like over its whole life.
  typedef struct {
    int         cpi;
    logic [1:0] npc;
    bit         grf;
    logic [1:0] a3;
    logic [2:0] wd;
    bit         dm;
    int         md_lat;
    logic [1:0] md_start;
    bit         alu_chk;
    logic [1:0] aluop;
    logic       bsel;
    bit         ext_chk;
    logic       extop;
  } exp_t;

  function automatic exp_t ref_model(input logic [5:0] op, input logic [5:0] fn, input logic z);
    exp_t e;
    e.cpi = 2; e.npc = 2'b00; e.grf = 0; e.a3 = 2'b00; e.wd = 3'b000; e.dm = 0;
    e.md_lat = 0; e.md_start = 2'b00; e.alu_chk = 0; e.aluop = 2'b00; e.bsel = 0;
    e.ext_chk = 0; e.extop = 0;
    if (op == 6'b000000) begin
      case (fn)
        6'b100001: begin e.cpi = 4; e.grf = 1; e.alu_chk = 1; e.aluop = 2'b00; end
        6'b100011: begin e.cpi = 4; e.grf = 1; e.alu_chk = 1; e.aluop = 2'b01; end
        6'b001000: begin e.cpi = 2; e.npc = 2'b11; end
        6'b011000: begin e.cpi = 2 + MULT_LAT; e.md_lat = MULT_LAT; e.md_start = 2'b01; end
        6'b011010: begin e.cpi = 2 + DIV_LAT; e.md_lat = DIV_LAT; e.md_start = 2'b10; end
        6'b010000: begin e.cpi = 3; e.grf = 1; e.wd = 3'b100; end
        6'b010010: begin e.cpi = 3; e.grf = 1; e.wd = 3'b101; end
        default:   e.cpi = 2;
      endcase
    end else begin
      case (op)
        6'b001101: begin
          e.cpi = 4; e.grf = 1; e.a3 = 2'b01; e.alu_chk = 1; e.aluop = 2'b10; e.bsel = 1;
          e.ext_chk = 1; e.extop = 0;
        end
        6'b100011: begin
          e.cpi = 5; e.grf = 1; e.a3 = 2'b01; e.wd = 3'b001; e.alu_chk = 1; e.bsel = 1;
          e.ext_chk = 1; e.extop = 1;
        end
        6'b101011: begin
          e.cpi = 4; e.dm = 1; e.alu_chk = 1; e.bsel = 1; e.ext_chk = 1; e.extop = 1;
        end
        6'b000100: begin e.cpi = 3; e.npc = z ? 2'b01 : 2'b00; e.alu_chk = 1; e.aluop = 2'b01; end
        6'b000011: begin e.cpi = 3; e.grf = 1; e.a3 = 2'b10; e.wd = 3'b010; e.npc = 2'b10; end
        6'b001111: begin e.cpi = 4; e.grf = 1; e.a3 = 2'b01; e.wd = 3'b011; end
        default:   e.cpi = 2;
      endcase
    end
    return e;
  endfunction

  // Called on a falling edge with the DUT in its fetch cycle; returns on the
  // falling edge of the following fetch cycle.
  task automatic run_insn(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic z);
    exp_t e;
    int ret_cyc = 0, pc_n = 0, rt_bad = 0, ir_n = 0, ir_cyc = 0;
    int grf_n = 0, grf_cyc = 0, dm_n = 0, dm_cyc = 0, busy_n = 0, st_n = 0;
    logic [1:0] npc_r = 2'b00, a3_r = 2'b00, st3 = 2'b00, alu3 = 2'b00;
    logic [2:0] wd_r = 3'b000;
    logic bsel3 = 1'b0, ext3 = 1'b0;
    e = ref_model(op, fn, z);
    opcode = op; funct = fn; zero = z;
    for (int c = 1; c <= MAX_CYC && ret_cyc == 0; c++) begin
      #1;
      if (retire !== PCWr) rt_bad++;
      if (IRWr === 1'b1) begin ir_n++; if (ir_cyc == 0) ir_cyc = c; end
      if (GRFWr === 1'b1) begin grf_n++; grf_cyc = c; end
      if (DMWr === 1'b1) begin dm_n++; dm_cyc = c; end
      if (MDBusy === 1'b1) busy_n++;
      if (MDStart !== 2'b00) st_n++;
      if (c == 3) begin st3 = MDStart; alu3 = ALUOp; bsel3 = BSel; ext3 = EXTOp; end
      if (PCWr === 1'b1) begin
        pc_n++; ret_cyc = c; npc_r = NPCOp; a3_r = A3Sel; wd_r = WDSel;
      end
      @(negedge clk);
    end
    tests++;
    if (ret_cyc !== e.cpi) begin
      fails++; $display("FAIL %s retire_cycle: got %0d expected %0d", nm, ret_cyc, e.cpi);
    end
    tests++;
    if (pc_n !== 1 || rt_bad !== 0) begin
      fails++; $display("FAIL %s pcwr_pulse: got %0d pulses, %0d retire!=PCWr cycles, expected 1 and 0", nm, pc_n, rt_bad);
    end
    tests++;
    if (ir_n !== 1 || ir_cyc !== 1) begin
      fails++; $display("FAIL %s irwr: got %0d pulses first at %0d, expected 1 at cycle 1", nm, ir_n, ir_cyc);
    end
    tests++;
    if (npc_r !== e.npc) begin
      fails++; $display("FAIL %s npcop: got %b expected %b", nm, npc_r, e.npc);
    end
    tests++;
    if (grf_n !== int'(e.grf)) begin
      fails++; $display("FAIL %s grfwr_count: got %0d expected %0d", nm, grf_n, e.grf);
    end
    if (e.grf) begin
      tests++;
      if (grf_cyc !== e.cpi || a3_r !== e.a3 || wd_r !== e.wd) begin
        fails++; $display("FAIL %s writeback: got cyc=%0d A3Sel=%b WDSel=%b expected cyc=%0d A3Sel=%b WDSel=%b",
                          nm, grf_cyc, a3_r, wd_r, e.cpi, e.a3, e.wd);
      end
    end
    tests++;
    if (dm_n !== int'(e.dm) || (e.dm && dm_cyc !== e.cpi)) begin
      fails++; $display("FAIL %s dmwr: got %0d pulses at %0d expected %0d at %0d", nm, dm_n, dm_cyc, e.dm, e.cpi);
    end
    tests++;
    if (busy_n !== e.md_lat || st3 !== e.md_start || st_n !== ((e.md_lat > 0) ? 1 : 0)) begin
      fails++; $display("FAIL %s md: got busy=%0d start=%b starts=%0d expected busy=%0d start=%b",
                        nm, busy_n, st3, st_n, e.md_lat, e.md_start);
    end
    if (e.alu_chk) begin
      tests++;
      if (alu3 !== e.aluop || bsel3 !== e.bsel || (e.ext_chk && ext3 !== e.extop)) begin
        fails++; $display("FAIL %s exec_alu: got ALUOp=%b BSel=%b EXTOp=%b expected ALUOp=%b BSel=%b EXTOp=%b",
                          nm, alu3, bsel3, ext3, e.aluop, e.bsel, e.extop);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = OP_ORI; funct = 6'd0; zero = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      tests++;
      if ({PCWr, IRWr, GRFWr, DMWr, retire, MDBusy, MDStart} !== 8'd0) begin
        fails++; $display("FAIL reset_enables: got %b expected 0", {PCWr, IRWr, GRFWr, DMWr, retire, MDBusy, MDStart});
      end
      tests++;
      if ({NPCOp, EXTOp, ALUOp, A3Sel, WDSel, BSel} !== 11'd0) begin
        fails++; $display("FAIL reset_selects: got %b expected 0", {NPCOp, EXTOp, ALUOp, A3Sel, WDSel, BSel});
      end
      tests++;
      if (state_dbg !== S_FETCH || md_cnt_dbg !== 4'd0) begin
        fails++; $display("FAIL reset_state: got state=%0d md_cnt=%0d expected 0 0", state_dbg, md_cnt_dbg);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    run_insn("ori", OP_ORI, 6'd0, 1'b0);
  endtask

  task automatic test_lw_sw();
    run_insn("lw", OP_LW, 6'($urandom_range(0, 63)), 1'b0);
    run_insn("sw", OP_SW, 6'($urandom_range(0, 63)), 1'b0);
  endtask

  task automatic test_beq();
    run_insn("beq_taken", OP_BEQ, 6'd0, 1'b1);
    run_insn("beq_not_taken", OP_BEQ, 6'd0, 1'b0);
  endtask

  task automatic test_jal_jr();
    run_insn("jal", OP_JAL, 6'd0, 1'b0);
    run_insn("jr", OP_RTYPE, FN_JR, 1'b0);
  endtask

  task automatic test_mult_div();
    run_insn("mult", OP_RTYPE, FN_MULT, 1'b0);
    run_insn("mflo", OP_RTYPE, FN_MFLO, 1'b0);
    run_insn("div", OP_RTYPE, FN_DIV, 1'b0);
    run_insn("mfhi", OP_RTYPE, FN_MFHI, 1'b0);
  endtask

  task automatic test_reset_abort();
    int pc_seen = 0;
    opcode = OP_RTYPE; funct = FN_DIV; zero = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      if (PCWr === 1'b1) pc_seen++;
      @(negedge clk);
    end
    #1;
    tests++;
    if (MDBusy !== 1'b1 || MDStart !== 2'b00 || pc_seen !== 0) begin
      fails++; $display("FAIL abort_pre: got MDBusy=%b MDStart=%b pcwr=%0d expected 1 00 0", MDBusy, MDStart, pc_seen);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (state_dbg !== S_FETCH || md_cnt_dbg !== 4'd0) begin
      fails++; $display("FAIL abort_state: got state=%0d md_cnt=%0d expected 0 0", state_dbg, md_cnt_dbg);
    end
    tests++;
    if ({PCWr, GRFWr, DMWr, MDBusy, MDStart} !== 6'd0) begin
      fails++; $display("FAIL abort_enables: got %b expected 0", {PCWr, GRFWr, DMWr, MDBusy, MDStart});
    end
    @(negedge clk);
    reset = 1'b0;
    run_insn("unknown_op", 6'b111111, 6'($urandom_range(0, 63)), 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [14] = '{OP_RTYPE, OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_JAL,
                             OP_RTYPE, OP_LUI, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, 6'b110011};
    logic [5:0] fns [14] = '{FN_ADDU, FN_SUBU, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0,
                             FN_JR, 6'd0, FN_MULT, FN_DIV, FN_MFHI, FN_MFLO, 6'd0};
    for (int i = 0; i < 40; i++) begin
      int k = $urandom_range(0, 14);
      if (k == 14) run_insn("rand_bad_funct", OP_RTYPE, 6'b000001, 1'($urandom_range(0, 1)));
      else run_insn($sformatf("rand_%0d", k), ops[k], fns[k], 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
    test_reset();
    test_lw_sw();
    test_beq();
    test_jal_jr();
    test_mult_div();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
